index_reg_seq: RTL and testbench

Multi-cycle sequencer that executes the 4004 index-register instructions by driving the 16×4 register file's single and pair ports. It sits between the instruction decoder and `registerFile`. It accepts one decoded op per handshake, performs its reads and writes, and optionally fetches a ROM byte for FIN. It then returns accumulator, address and branch results to the datapath with a one-cycle `done` pulse.

---
 rtl/tb4004_pkg.sv | 34 +++
 rtl/index_reg_seq.sv | 173 +++++++++++++++++
 tb/tb_index_reg_seq.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb4004_pkg.sv
// rtl/tb4004_pkg.sv - 4004 index-register op encodings and sequencer state constants
package tb4004_pkg;

    // Decoded index-register op select (3 bits, every code is a defined op).
    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_XCH = 3'd1,
        OP_INC = 3'd2,
        OP_ISZ = 3'd3,
        OP_FIM = 3'd4,
        OP_SRC = 3'd5,
        OP_FIN = 3'd6,
        OP_JIN = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Ops that read-modify-write a single register during EXEC.
    function automatic logic op_writes_reg(input op_e op);
        return (op == OP_XCH) || (op == OP_INC) || (op == OP_ISZ);
    endfunction

    // Even register of the pair addressed by a register index.
    function automatic logic [3:0] pair_base(input logic [3:0] idx);
        return {idx[3:1], 1'b0};
    endfunction

endpackage

// File: rtl/index_reg_seq.sv
// rtl/index_reg_seq.sv - multi-cycle sequencer for 4004 index-register instructions
//
// Ports:
//   clk, rstN                      clock, asynchronous active-low reset
//   opValid/opReady                op handshake from the decoder (ready only in IDLE)
//   opCode, opReg, opImm, accIn    decoded op, register index, immediate, accumulator
//   regWe/regAddr/regDin/regDout   single-register port of the register file
//   pairWe/pairAddr/pairDin/pairDout  register-pair port of the register file
//   romReq/romAddr/romAck/romData  FIN byte fetch
//   done                           one-cycle completion pulse qualifying the results
//   accWe/accOut                   accumulator write-back (LD, XCH)
//   addrValid/addrOut              SRC/JIN address or taken ISZ target
//   jumpTaken                      ISZ incremented value is nonzero
//   opErr                          op code not recognised
module index_reg_seq
    import tb4004_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       opValid,
    output logic       opReady,
    input  logic [2:0] opCode,
    input  logic [3:0] opReg,
    input  logic [7:0] opImm,
    input  logic [3:0] accIn,
    output logic       regWe,
    output logic       pairWe,
    output logic [3:0] regAddr,
    output logic [3:0] pairAddr,
    output logic [3:0] regDin,
    output logic [7:0] pairDin,
    input  logic [3:0] regDout,
    input  logic [7:0] pairDout,
    output logic       romReq,
    output logic [7:0] romAddr,
    input  logic       romAck,
    input  logic [7:0] romData,
    output logic       done,
    output logic       accWe,
    output logic [3:0] accOut,
    output logic       addrValid,
    output logic [7:0] addrOut,
    output logic       jumpTaken,
    output logic       opErr
);

    state_e     state_q;
    op_e        op_q;
    logic [3:0] reg_q;
    logic [7:0] imm_q;
    logic [3:0] acc_q;
    logic [7:0] rom_q;
    logic [7:0] rom_addr_q;
    logic [3:0] acc_out_q;
    logic [7:0] addr_out_q;
    logic       done_q;
    logic       acc_we_q;
    logic       addr_valid_q;
    logic       jump_q;
    logic       err_q;

    // Increment result shared by INC/ISZ; wraps 15 -> 0.
    logic [3:0] inc_val;
    assign inc_val = regDout + 4'd1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LD;
            reg_q        <= 4'd0;
            imm_q        <= 8'd0;
            acc_q        <= 4'd0;
            rom_q        <= 8'd0;
            rom_addr_q   <= 8'd0;
            acc_out_q    <= 4'd0;
            addr_out_q   <= 8'd0;
            done_q       <= 1'b0;
            acc_we_q     <= 1'b0;
            addr_valid_q <= 1'b0;
            jump_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Result strobes live for exactly the DONE cycle.
            done_q       <= 1'b0;
            acc_we_q     <= 1'b0;
            addr_valid_q <= 1'b0;
            jump_q       <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (opValid) begin
                        op_q    <= op_e'(opCode);
                        reg_q   <= opReg;
                        imm_q   <= opImm;
                        acc_q   <= accIn;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    case (op_q)
                        OP_LD, OP_XCH: begin
                            // Old register value is sampled here; XCH's write of
                            // acc_q commits on this same edge.
                            acc_out_q <= regDout;
                            acc_we_q  <= 1'b1;
                        end
                        OP_INC, OP_FIM: begin
                        end
                        OP_ISZ: begin
                            jump_q       <= (inc_val != 4'd0);
                            addr_valid_q <= (inc_val != 4'd0);
                            addr_out_q   <= imm_q;
                        end
                        OP_SRC, OP_JIN: begin
                            addr_out_q   <= pairDout;
                            addr_valid_q <= 1'b1;
                        end
                        OP_FIN: begin
                            // pairDout is pair 0 here (forced read address).
                            rom_addr_q <= pairDout;
                            state_q    <= ST_FETCH;
                            done_q     <= 1'b0;
                        end
                        default: begin
                            err_q <= 1'b1;
                        end
                    endcase
                end
                ST_FETCH: begin
                    if (romAck) begin
                        rom_q   <= romData;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign opReady = (state_q == ST_IDLE);

    // Register-file port drive. Addresses come from latched fields so the
    // combinational read data is valid throughout EXEC.
    assign regAddr  = reg_q;
    assign pairAddr = ((state_q == ST_EXEC) && (op_q == OP_FIN)) ? 4'd0 : pair_base(reg_q);
    assign regWe    = (state_q == ST_EXEC) && op_writes_reg(op_q);
    assign pairWe   = ((state_q == ST_EXEC) && (op_q == OP_FIM)) || (state_q == ST_WRITE);
    assign regDin   = (op_q == OP_XCH) ? acc_q : inc_val;
    assign pairDin  = (state_q == ST_WRITE) ? rom_q : imm_q;

    assign romReq  = (state_q == ST_FETCH);
    assign romAddr = rom_addr_q;

    assign done      = done_q;
    assign accWe     = acc_we_q;
    assign accOut    = acc_out_q;
    assign addrValid = addr_valid_q;
    assign addrOut   = addr_out_q;
    assign jumpTaken = jump_q;
    assign opErr     = err_q;

endmodule

// File: tb/tb_index_reg_seq.sv
// tb/tb_index_reg_seq.sv - scoreboard bench for index_reg_seq with a register file and ROM model
module tb_index_reg_seq;
    import tb4004_pkg::*;

    logic       clk = 1'b0;
    logic       rstN;
    logic       opValid;
    logic       opReady;
    logic [2:0] opCode;
    logic [3:0] opReg;
    logic [7:0] opImm;
    logic [3:0] accIn;
    logic       regWe, pairWe;
    logic [3:0] regAddr, pairAddr;
    logic [3:0] regDin;
    logic [7:0] pairDin;
    logic [3:0] regDout;
    logic [7:0] pairDout;
    logic       romReq;
    logic [7:0] romAddr;
    logic       romAck;
    logic [7:0] romData;
    logic       done, accWe, addrValid, jumpTaken, opErr;
    logic [3:0] accOut;
    logic [7:0] addrOut;

    always #5 clk = ~clk;

    index_reg_seq dut (
        .clk(clk), .rstN(rstN),
        .opValid(opValid), .opReady(opReady), .opCode(opCode), .opReg(opReg),
        .opImm(opImm), .accIn(accIn),
        .regWe(regWe), .pairWe(pairWe), .regAddr(regAddr), .pairAddr(pairAddr),
        .regDin(regDin), .pairDin(pairDin), .regDout(regDout), .pairDout(pairDout),
        .romReq(romReq), .romAddr(romAddr), .romAck(romAck), .romData(romData),
        .done(done), .accWe(accWe), .accOut(accOut), .addrValid(addrValid),
        .addrOut(addrOut), .jumpTaken(jumpTaken), .opErr(opErr)
    );

    // Register file: 16x4, combinational reads, writes at the clock edge.
    logic [3:0] rf [16];
    assign regDout  = rf[regAddr];
    assign pairDout = {rf[{pairAddr[3:1], 1'b0}], rf[{pairAddr[3:1], 1'b1}]};

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 16; i++) rf[i] <= 4'd0;
        end else begin
            if (regWe) rf[regAddr] <= regDin;
            if (pairWe) begin
                rf[{pairAddr[3:1], 1'b0}] <= pairDin[7:4];
                rf[{pairAddr[3:1], 1'b1}] <= pairDin[3:0];
            end
        end
    end

    function automatic logic [63:0] rf_vec();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = rf[i];
        return v;
    endfunction

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return a + 8'h42;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: register contents and last result values.
    typedef struct {
        logic        acc_we;
        logic [3:0]  acc_out;
        logic        addr_valid;
        logic [7:0]  addr_out;
        logic        jump;
        logic        is_fin;
        logic [7:0]  rom_addr;
        logic [63:0] rf_after;
        int          acc_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_rf [16];
    logic [3:0] m_acc_out;
    logic [7:0] m_addr_out;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 4'd0;
        m_acc_out  = 4'd0;
        m_addr_out = 8'd0;
    endtask

    function automatic exp_t model_op(input int op, input int r, input int imm, input int acc);
        exp_t e;
        int   ev, n, ptr, d;
        ev = r - (r % 2);
        e.acc_we = 0; e.addr_valid = 0; e.jump = 0; e.is_fin = 0; e.rom_addr = 8'd0;
        case (op)
            0: begin m_acc_out = m_rf[r]; e.acc_we = 1; end
            1: begin m_acc_out = m_rf[r]; m_rf[r] = 4'(acc); e.acc_we = 1; end
            2: m_rf[r] = 4'((m_rf[r] + 1) % 16);
            3: begin
                n = (m_rf[r] + 1) % 16;
                m_rf[r] = 4'(n);
                e.jump = (n != 0);
                e.addr_valid = (n != 0);
                m_addr_out = 8'(imm);
            end
            4: begin m_rf[ev] = 4'(imm / 16); m_rf[ev+1] = 4'(imm % 16); end
            5, 7: begin
                m_addr_out = 8'(m_rf[ev] * 16 + m_rf[ev+1]);
                e.addr_valid = 1;
            end
            default: begin
                ptr = m_rf[0] * 16 + m_rf[1];
                d = rom_fn(8'(ptr));
                e.is_fin = 1;
                e.rom_addr = 8'(ptr);
                m_rf[ev] = 4'(d / 16);
                m_rf[ev+1] = 4'(d % 16);
            end
        endcase
        e.acc_out = m_acc_out;
        e.addr_out = m_addr_out;
        for (int i = 0; i < 16; i++) e.rf_after[i*4 +: 4] = m_rf[i];
        return e;
    endfunction

    // Drive one op: wait (bounded) for opReady, present it, return after acceptance.
    task automatic issue(input int op, input int r, input int imm, input int acc);
        exp_t e;
        int   k;
        @(negedge clk);
        k = 0;
        while (!opReady && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!opReady) begin
            chk("ready_timeout", opReady, 1);
        end else begin
            e = model_op(op, r, imm, acc);
            e.acc_cyc = cyc;
            sb.push_back(e);
            opValid = 1'b1;
            opCode  = 3'(op);
            opReg   = 4'(r);
            opImm   = 8'(imm);
            accIn   = 4'(acc);
            @(posedge clk);
            #1;
            opValid = 1'b0;
            opCode  = 3'($urandom);
            opReg   = 4'($urandom);
            opImm   = 8'($urandom);
            accIn   = 4'($urandom);
        end
    endtask

    // ROM responder: acks after rom_delay FETCH cycles, injects stray acks otherwise.
    int rom_delay = 0;
    int wait_cnt = 0;
    int last_ack_cyc = 0;
    initial begin
        romAck = 1'b0;
        romData = 8'h00;
        forever begin
            @(negedge clk);
            romAck = 1'b0;
            romData = 8'($urandom);
            if (rstN && romReq) begin
                if (wait_cnt >= rom_delay) begin
                    romAck = 1'b1;
                    romData = rom_fn(romAddr);
                    last_ack_cyc = cyc;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if ($urandom_range(0, 3) == 0) romAck = 1'b1;
            end
        end
    end

    // Monitor: per-cycle invariants and scoreboard pops on done.
    logic [7:0] fetch_addr;
    logic       in_fetch = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstN) begin
                if (regWe && pairWe) chk("we_exclusive", {regWe, pairWe}, 2'b00);
                if (!done) chk("strobes_outside_done", {accWe, addrValid, jumpTaken, opErr}, 4'b0);
                if (romReq) begin
                    if (sb.size() > 0) chk("rom_addr", romAddr, sb[0].rom_addr);
                    if (in_fetch) chk("rom_addr_stable", romAddr, fetch_addr);
                    chk("fetch_no_write", {regWe, pairWe}, 2'b00);
                    fetch_addr = romAddr;
                    in_fetch = 1'b1;
                end else begin
                    in_fetch = 1'b0;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("accWe", accWe, e.acc_we);
                        chk("accOut", accOut, e.acc_out);
                        chk("addrValid", addrValid, e.addr_valid);
                        chk("addrOut", addrOut, e.addr_out);
                        chk("jumpTaken", jumpTaken, e.jump);
                        chk("opErr", opErr, 0);
                        chk("regfile", rf_vec(), e.rf_after);
                        if (e.is_fin) chk("fin_latency", cyc - last_ack_cyc, 2);
                        else          chk("latency", cyc - e.acc_cyc, 2);
                    end
                end
            end else begin
                in_fetch = 1'b0;
            end
        end
    end

    initial begin
        int k;
        rstN = 1'b0;
        opValid = 1'b0;
        opCode = 3'd0; opReg = 4'd0; opImm = 8'd0; accIn = 4'd0;
        model_reset();
        #1;
        chk("reset_opReady", opReady, 1);
        chk("reset_outputs", {done, accWe, accOut, addrValid, addrOut, jumpTaken, opErr, romReq, regWe, pairWe},
            '0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        // FIM then SRC on the odd half of the same pair.
        issue(OP_FIM, 4, 8'hA5, 0);
        issue(OP_SRC, 5, 0, 0);
        // INC wrap then ISZ taken, and ISZ not taken.
        issue(OP_FIM, 2, 8'h0F, 0);
        issue(OP_INC, 3, 0, 0);
        issue(OP_ISZ, 3, 8'h40, 0);
        issue(OP_FIM, 2, 8'h0F, 0);
        issue(OP_ISZ, 3, 8'h77, 0);
        // XCH then LD of the exchanged register.
        issue(OP_FIM, 6, 8'h09, 0);
        issue(OP_XCH, 7, 0, 2);
        issue(OP_LD, 7, 0, 0);
        // FIN through pointer 0x3C with a 4-cycle ROM delay.
        issue(OP_FIM, 0, 8'h3C, 0);
        rom_delay = 4;
        issue(OP_FIN, 6, 0, 0);
        issue(OP_JIN, 6, 0, 0);
        issue(OP_FIN, 0, 0, 0);
        issue(OP_SRC, 0, 0, 0);

        // Reset during FETCH aborts the FIN.
        rom_delay = 20;
        issue(OP_FIN, 2, 0, 0);
        k = 0;
        while (!romReq && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("fin_reaches_fetch", romReq, 1);
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        chk("rst_romReq_async", romReq, 0);
        chk("rst_no_pairWe", pairWe, 0);
        sb.delete();
        model_reset();
        @(negedge clk);
        chk("rst_opReady", opReady, 1);
        chk("rst_results", {done, accOut, addrOut, romAddr}, '0);
        chk("rst_regfile", rf_vec(), 64'd0);
        rstN = 1'b1;

        // Randomized ops.
        for (int i = 0; i < 250; i++) begin
            rom_delay = $urandom_range(0, 5);
            issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 15));
        end

        k = 0;
        while (sb.size() > 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
